vlc_bit_packer: RTL and testbench

Packs variable-length codewords into a continuous MSB-first bitstream of 32-bit words. Sits directly downstream of the DC/AC entropy coders: each coder cycle delivers one codeword (value plus bit length) and this block concatenates them into words for the slice/frame writer. A flush request drains the accumulator, zero-pads the final word and reports its valid byte count, closing a slice.

---
 rtl/vlc_bit_packer_if.sv | 26 ++
 rtl/vlc_bit_packer.sv | 129 ++++++++++++
 tb/tb_vlc_bit_packer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/vlc_bit_packer_if.sv
// Codeword input, packed-word output and slice-control signals of vlc_bit_packer.
// master = upstream coder / downstream writer side, slave = the packer itself.
interface vlc_bit_packer_if;
  logic        code_valid;
  logic [23:0] code_value;
  logic [4:0]  code_length;
  logic        code_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [2:0]  out_nbytes;
  logic        flush_done;
  logic        busy;
  logic [31:0] total_bits;

  modport master (
    output code_valid, code_value, code_length, flush, out_ready,
    input  code_ready, out_valid, out_word, out_nbytes, flush_done, busy, total_bits
  );

  modport slave (
    input  code_valid, code_value, code_length, flush, out_ready,
    output code_ready, out_valid, out_word, out_nbytes, flush_done, busy, total_bits
  );
endinterface

// File: rtl/vlc_bit_packer.sv
// Packs variable-length codewords MSB-first into 32-bit words; flush closes a slice.
// Optional macro VLC_BIT_PACKER_BITCOUNT_EN builds the per-slice accepted-bit counter.
module vlc_bit_packer (
  input  logic               clk,
  input  logic               reset,
  vlc_bit_packer_if.slave    bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CODE_W = 24;
  localparam int unsigned ACC_W  = 56;
  localparam int unsigned FILL_W = 6;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned NB_W   = 3;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [FILL_W-1:0]   r_fill;
  logic                r_out_valid;
  logic [WORD_W-1:0]   r_out_word;
  logic [NB_W-1:0]     r_out_nbytes;
  logic                r_flush_done;

  logic [LEN_W-1:0]    w_len;
  logic [CODE_W-1:0]   w_mask;
  logic [CODE_W-1:0]   w_val;
  logic [FILL_W-1:0]   w_shamt;
  logic [ACC_W-1:0]    w_placed;
  logic                w_code_ready;
  logic                w_accept;
  logic                w_slot_free;
  logic                w_emit_full;
  logic                w_drain_last;
  logic [NB_W-1:0]     w_part_nbytes;

  // Codeword saturation, masking and left-alignment behind the current fill.
  always_comb begin
    w_len         = (bus.code_length > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : bus.code_length;
    w_mask        = CODE_W'((25'(1) << w_len) - 25'(1));
    w_val         = bus.code_value & w_mask;
    w_shamt       = FILL_W'(7'(ACC_W) - 7'(r_fill) - 7'(w_len));
    w_placed      = ACC_W'(w_val) << w_shamt;
    w_code_ready  = (r_state == ST_RUN) && (r_fill < FILL_W'(WORD_W));
    w_accept      = bus.code_valid && w_code_ready;
    w_slot_free   = !r_out_valid || bus.out_ready;
    w_emit_full   = (r_fill >= FILL_W'(WORD_W)) && w_slot_free;
    w_drain_last  = (r_state == ST_DRAIN) && (r_fill < FILL_W'(WORD_W)) && w_slot_free;
    w_part_nbytes = NB_W'((r_fill + FILL_W'(7)) >> 3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_acc        <= '0;
      r_fill       <= '0;
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_out_nbytes <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (bus.out_ready) r_out_valid <= 1'b0;

      // Full-word emit takes priority; accept can only happen when fill < 32.
      if (w_emit_full) begin
        r_out_word   <= r_acc[ACC_W-1 -: WORD_W];
        r_out_nbytes <= NB_W'(4);
        r_out_valid  <= 1'b1;
        r_acc        <= r_acc << WORD_W;
        r_fill       <= r_fill - FILL_W'(WORD_W);
      end else if (w_accept) begin
        r_acc        <= r_acc | w_placed;
        r_fill       <= r_fill + FILL_W'(w_len);
      end

      case (r_state)
        ST_RUN: begin
          if (bus.flush) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_drain_last) begin
            if (r_fill != '0) begin
              r_out_word   <= r_acc[ACC_W-1 -: WORD_W];
              r_out_nbytes <= w_part_nbytes;
              r_out_valid  <= 1'b1;
              r_acc        <= '0;
              r_fill       <= '0;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_flush_done <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef VLC_BIT_PACKER_BITCOUNT_EN
  logic [WORD_W-1:0] r_total_bits;

  // Per-slice count; clears on the same edge that raises flush_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total_bits <= '0;
    end else if ((r_state == ST_DONE) && !r_out_valid) begin
      r_total_bits <= '0;
    end else if (w_accept) begin
      r_total_bits <= r_total_bits + WORD_W'(w_len);
    end
  end

  assign bus.total_bits = r_total_bits;
`else
  assign bus.total_bits = '0;
`endif

  assign bus.code_ready = w_code_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_word   = r_out_word;
  assign bus.out_nbytes = r_out_nbytes;
  assign bus.flush_done = r_flush_done;
  assign bus.busy       = (r_state != ST_RUN);
endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed-vector bench for vlc_bit_packer with hand-computed expected words.
module tb_vlc_bit_packer;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n_done;
  logic [34:0] q_words[$];

  vlc_bit_packer_if bus();

  vlc_bit_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes complete at the next rising edge; inputs only change 1ns after it.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready)
      q_words.push_back({bus.out_nbytes, bus.out_word});
    if (!reset && bus.flush_done)
      n_done++;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] v, input logic [4:0] l);
    logic got;
    got = 1'b0;
    bus.code_valid  = 1'b1;
    bus.code_value  = v;
    bus.code_length = l;
    for (int i = 0; i < 64 && !got; i++) begin
      if (bus.code_ready) got = 1'b1;
      tick();
    end
    bus.code_valid = 1'b0;
    if (!got) chk_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int i = 0; i < 60 && n_done == prev; i++) tick();
    chk_val(tag, 32'(n_done), 32'(prev + 1));
  endtask

  task automatic pop_word(input string tag, input logic [31:0] exp_w, input logic [2:0] exp_nb);
    logic [34:0] e;
    if (q_words.size() == 0) begin
      chk_val({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      e = q_words.pop_front();
      chk_val({tag, "_word"}, e[31:0], exp_w);
      chk_val({tag, "_nbytes"}, 32'(e[34:32]), 32'(exp_nb));
    end
  endtask

  initial begin
    int prev;
    logic got;
    n_vec  = 0;
    n_err  = 0;
    n_done = 0;
    bus.code_valid  = 1'b0;
    bus.code_value  = '0;
    bus.code_length = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk_val("rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk_val("rst_out_word",   bus.out_word,        32'd0);
    chk_val("rst_out_nbytes", 32'(bus.out_nbytes), 32'd0);
    chk_val("rst_busy",       32'(bus.busy),       32'd0);
    chk_val("rst_flush_done", 32'(bus.flush_done), 32'd0);
    chk_val("rst_total_bits", bus.total_bits,      32'd0);
    tick();
    chk_val("rst_code_ready", 32'(bus.code_ready), 32'd1);

    // Three bytes then flush: one 3-byte partial word.
    prev = n_done;
    send(24'hA5, 5'd8);
    send(24'h3C, 5'd8);
    send(24'hFF, 5'd8);
    chk_val("t1_no_early_word", 32'(bus.out_valid), 32'd0);
    do_flush();
    wait_done("t1_flush_done", prev);
    pop_word("t1", 32'hA53CFF00, 3'd4 - 3'd1);
    chk_val("t1_qempty", 32'(q_words.size()), 32'd0);

    // Four bytes make a full word before any flush.
    send(24'h11, 5'd8);
    send(24'h22, 5'd8);
    send(24'h33, 5'd8);
    send(24'h44, 5'd8);
    repeat (3) tick();
    pop_word("t2", 32'h11223344, 3'd4);
    // Empty-accumulator flush timing: DRAIN, DONE, then a single flush_done pulse.
    prev = n_done;
    do_flush();
    chk_val("t2_busy_n1", 32'(bus.busy), 32'd1);
    tick();
    chk_val("t2_busy_n2", 32'(bus.busy), 32'd1);
    chk_val("t2_fd_early", 32'(bus.flush_done), 32'd0);
    tick();
    chk_val("t2_fd_pulse", 32'(bus.flush_done), 32'd1);
    chk_val("t2_busy_end", 32'(bus.busy), 32'd0);
    tick();
    chk_val("t2_fd_one_cycle", 32'(bus.flush_done), 32'd0);
    chk_val("t2_done_count", 32'(n_done), 32'(prev + 1));
    chk_val("t2_no_extra", 32'(q_words.size()), 32'd0);

    // Upper bits above code_length are masked.
    prev = n_done;
    send(24'hFFFFFF, 5'd3);
    send(24'h000000, 5'd5);
    do_flush();
    wait_done("t3_flush_done", prev);
    pop_word("t3", 32'hE0000000, 3'd1);

    // Backpressure: 4 x 24-bit codewords while the sink stalls.
    prev = n_done;
    bus.out_ready = 1'b0;
    send(24'hABCDEF, 5'd24);
    send(24'hABCDEF, 5'd24);
    send(24'hABCDEF, 5'd24);
    bus.code_valid  = 1'b1;
    bus.code_value  = 24'hABCDEF;
    bus.code_length = 5'd24;
    repeat (10) tick();
    chk_val("t4_code_ready_low", 32'(bus.code_ready), 32'd0);
    chk_val("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    chk_val("t4_hold_word", bus.out_word, 32'hABCDEFAB);
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.code_ready) got = 1'b1;
      tick();
    end
    bus.code_valid = 1'b0;
    chk_val("t4_fourth_accepted", 32'(got), 32'd1);
    do_flush();
    wait_done("t4_flush_done", prev);
    pop_word("t4a", 32'hABCDEFAB, 3'd4);
    pop_word("t4b", 32'hCDEFABCD, 3'd4);
    pop_word("t4c", 32'hEFABCDEF, 3'd4);
    chk_val("t4_qempty", 32'(q_words.size()), 32'd0);

    // Length saturation and zero-length codeword; bit counter follows.
    prev = n_done;
    send(24'hFFFFFF, 5'd31);
    send(24'h000123, 5'd0);
`ifdef VLC_BIT_PACKER_BITCOUNT_EN
    chk_val("t5_total_bits", bus.total_bits, 32'd24);
`else
    chk_val("t5_total_bits", bus.total_bits, 32'd0);
`endif
    do_flush();
    wait_done("t5_flush_done", prev);
    pop_word("t5", 32'hFFFFFF00, 3'd3);
    chk_val("t5_total_cleared", bus.total_bits, 32'd0);

    // Reset while stuck in DRAIN with a word pending.
    prev = n_done;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(24'h11, 5'd8);
    do_flush();
    tick();
    chk_val("t6_busy_pre", 32'(bus.busy), 32'd1);
    chk_val("t6_valid_pre", 32'(bus.out_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk_val("t6_valid_rst", 32'(bus.out_valid), 32'd0);
    chk_val("t6_word_rst", bus.out_word, 32'd0);
    chk_val("t6_nbytes_rst", 32'(bus.out_nbytes), 32'd0);
    chk_val("t6_busy_rst", 32'(bus.busy), 32'd0);
    chk_val("t6_ready_rst", 32'(bus.code_ready), 32'd1);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk_val("t6_no_flush_done", 32'(n_done), 32'(prev));
    chk_val("t6_no_word", 32'(q_words.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
